// File: rtl/ctx_quant_pred.sv
// LOCO-I regular-mode front end: gradients, context quantization/sign merge, MED prediction, residual.
// Latency 3 cycles, no backpressure; MOD_REDUCE_EN enables modulo-256 residual reduction in stage 3.
module ctx_quant_pred #(
    parameter int T1 = 3,
    parameter int T2 = 7,
    parameter int T3 = 21
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] c,
    input  logic [7:0] d,
    input  logic [7:0] Ix,
    input  logic       END_LINE,
    output logic [8:0] q_idx,
    output logic       sign,
    output logic [7:0] Px,
    output logic [8:0] errval,
    output logic       run_flag,
    output logic       eol_out,
    output logic       en_out
);

    function automatic logic signed [3:0] quant(input logic signed [8:0] di);
        int v;
        v = int'(di);
        if (v <= -T3)      return -4'sd4;
        else if (v <= -T2) return -4'sd3;
        else if (v <= -T1) return -4'sd2;
        else if (v < 0)    return -4'sd1;
        else if (v == 0)   return 4'sd0;
        else if (v < T1)   return 4'sd1;
        else if (v < T2)   return 4'sd2;
        else if (v < T3)   return 4'sd3;
        else               return 4'sd4;
    endfunction

    // Stage 1 registers
    logic              v1_q, eol1_q;
    logic signed [8:0] d1_q, d2_q, d3_q;
    logic        [7:0] px1_q, ix1_q;
    // Stage 2 registers
    logic              v2_q, eol2_q, run2_q;
    logic signed [3:0] q1_q, q2_q, q3_q;
    logic signed [8:0] e2_q;
    logic        [7:0] px2_q;
    // Stage 3 (output) registers
    logic              en_out_q, eol_out_q, sign_q, run_q;
    logic        [8:0] q_idx_q, errval_q;
    logic        [7:0] px_q;

    // Stage 1 next-state
    logic signed [8:0] d1_d, d2_d, d3_d;
    logic        [7:0] px1_d, mx, mn;

    always_comb begin
        d1_d = $signed({1'b0, d}) - $signed({1'b0, b});
        d2_d = $signed({1'b0, b}) - $signed({1'b0, c});
        d3_d = $signed({1'b0, c}) - $signed({1'b0, a});
        mx   = (a > b) ? a : b;
        mn   = (a > b) ? b : a;
        if (c >= mx)      px1_d = mn;
        else if (c <= mn) px1_d = mx;
        else              px1_d = 8'(10'(a) + 10'(b) - 10'(c));
    end

    // Stage 2 next-state
    logic signed [3:0] q1_d, q2_d, q3_d;
    logic signed [8:0] e2_d;
    logic              run2_d;

    always_comb begin
        q1_d   = quant(d1_q);
        q2_d   = quant(d2_q);
        q3_d   = quant(d3_q);
        run2_d = (d1_q == 9'sd0) && (d2_q == 9'sd0) && (d3_q == 9'sd0);
        e2_d   = $signed({1'b0, ix1_q}) - $signed({1'b0, px1_q});
    end

    // Stage 3 next-state
    logic              neg;
    logic signed [3:0] q1m, q2m, q3m;
    logic signed [8:0] e_c, errval_d;
    logic signed [9:0] e_w;
    logic        [8:0] q_idx_d;

    always_comb begin
        // The first nonzero gradient decides the context sign; an all-zero context stays positive
        if (q1_q != 4'sd0)      neg = q1_q[3];
        else if (q2_q != 4'sd0) neg = q2_q[3];
        else                    neg = q3_q[3];
        q1m     = neg ? -q1_q : q1_q;
        q2m     = neg ? -q2_q : q2_q;
        q3m     = neg ? -q3_q : q3_q;
        e_c     = neg ? -e2_q : e2_q;
        q_idx_d = 9'(81 * int'(q1m) + 9 * int'(q2m) + int'(q3m));
        e_w     = 10'(e_c);
`ifdef MOD_REDUCE_EN
        if (e_w < -10'sd128)     e_w = e_w + 10'sd256;
        else if (e_w > 10'sd127) e_w = e_w - 10'sd256;
`endif
        errval_d = 9'(e_w);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            v1_q      <= 1'b0;
            eol1_q    <= 1'b0;
            d1_q      <= '0;
            d2_q      <= '0;
            d3_q      <= '0;
            px1_q     <= '0;
            ix1_q     <= '0;
            v2_q      <= 1'b0;
            eol2_q    <= 1'b0;
            run2_q    <= 1'b0;
            q1_q      <= '0;
            q2_q      <= '0;
            q3_q      <= '0;
            e2_q      <= '0;
            px2_q     <= '0;
            en_out_q  <= 1'b0;
            eol_out_q <= 1'b0;
            sign_q    <= 1'b0;
            run_q     <= 1'b0;
            q_idx_q   <= '0;
            errval_q  <= '0;
            px_q      <= '0;
        end else begin
            v1_q     <= en;
            v2_q     <= v1_q;
            en_out_q <= v2_q;
            if (en) begin
                eol1_q <= END_LINE;
                d1_q   <= d1_d;
                d2_q   <= d2_d;
                d3_q   <= d3_d;
                px1_q  <= px1_d;
                ix1_q  <= Ix;
            end
            if (v1_q) begin
                eol2_q <= eol1_q;
                run2_q <= run2_d;
                q1_q   <= q1_d;
                q2_q   <= q2_d;
                q3_q   <= q3_d;
                e2_q   <= e2_d;
                px2_q  <= px1_q;
            end
            if (v2_q) begin
                eol_out_q <= eol2_q;
                sign_q    <= neg;
                run_q     <= run2_q;
                q_idx_q   <= q_idx_d;
                errval_q  <= errval_d;
                px_q      <= px2_q;
            end
        end
    end

    assign q_idx    = q_idx_q;
    assign sign     = sign_q;
    assign Px       = px_q;
    assign errval   = errval_q;
    assign run_flag = run_q;
    assign eol_out  = eol_out_q;
    assign en_out   = en_out_q;

endmodule

// File: tb/tb_ctx_quant_pred.sv
// Scoreboard bench for ctx_quant_pred: directed vectors queue expected results, a negedge monitor checks them.
module tb_ctx_quant_pred;

    logic       clk = 1'b0, reset = 1'b0, en = 1'b0, END_LINE = 1'b0;
    logic [7:0] a = '0, b = '0, c = '0, d = '0, Ix = '0;
    logic [8:0] q_idx, errval;
    logic       sign, run_flag, eol_out, en_out;
    logic [7:0] Px;

    ctx_quant_pred dut (
        .clk(clk), .reset(reset), .en(en), .a(a), .b(b), .c(c), .d(d), .Ix(Ix),
        .END_LINE(END_LINE), .q_idx(q_idx), .sign(sign), .Px(Px), .errval(errval),
        .run_flag(run_flag), .eol_out(eol_out), .en_out(en_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [8:0] q;
        logic       s;
        logic [7:0] px;
        logic [8:0] e;
        logic       run;
        logic       eol;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0, checks = 0, n_out = 0, n_exp = 0;

`ifdef MOD_REDUCE_EN
    localparam int E_200 = -56;
    localparam int E_M255 = 1;
`else
    localparam int E_200 = 200;
    localparam int E_M255 = -255;
`endif

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t x;
        if (en_out) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_en_out: got en_out=1 expected none (cycle %0d)", cyc);
            end else begin
                x = sbq.pop_front();
                n_out++;
                chk("latency_cycle", cyc, x.cyc);
                chk("q_idx", int'(q_idx), int'(x.q));
                chk("sign", int'(sign), int'(x.s));
                chk("Px", int'(Px), int'(x.px));
                chk("errval", int'(errval), int'(x.e));
                chk("run_flag", int'(run_flag), int'(x.run));
                chk("eol_out", int'(eol_out), int'(x.eol));
            end
        end
    end

    task automatic issue(input bit push, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [7:0] ic, input logic [7:0] id, input logic [7:0] ix,
                         input logic eol, input int q, input logic s, input logic [7:0] px,
                         input int e, input logic run);
        @(posedge clk);
        #1;
        a = ia; b = ib; c = ic; d = id; Ix = ix; END_LINE = eol; en = 1'b1;
        if (push) begin
            sbq.push_back('{cyc + 3, 9'(q), s, px, 9'(e), run, eol});
            n_exp++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            en = 1'b0;
            END_LINE = 1'b0;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_en_out"}, int'(en_out), 0);
        chk({tag, "_q_idx"}, int'(q_idx), 0);
        chk({tag, "_sign"}, int'(sign), 0);
        chk({tag, "_Px"}, int'(Px), 0);
        chk({tag, "_errval"}, int'(errval), 0);
        chk({tag, "_run_flag"}, int'(run_flag), 0);
        chk({tag, "_eol_out"}, int'(eol_out), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1 reset = 1'b1;

        // push a     b    c    d    Ix   eol  q_idx s  Px   errval run
        issue(1, 100, 100, 100, 100, 100, 0,   0,  0, 100,    0,   1);  // flat
        issue(1,  10,  20,  30,  50,  15, 0, 300,  0,  10,    5,   0);  // positive context
        issue(1,  50,  30,  20,  10,  40, 0, 220,  1,  50,   10,   0);  // sign merge
        issue(1,   0,   0,   0,   0, 200, 0,   0,  0,   0, E_200,  1);  // mod reduction
        issue(1, 100,  50,  70,  70,  90, 0, 212,  0,  80,   10,   0);  // a+b-c predictor
        issue(1,  71,  47,  50,  50,  60, 0, 140,  0,  68,   -8,   0);  // D=+T1, -T1, -T3
        issue(1,  40,  47,  40,  40,  30, 0, 216,  1,  47,   17,   0);  // D=-T2, +T2
        issue(1,  60,  50,  50,  50,   0, 0,   3,  1,  60,   60,   0);  // only Q3 nonzero, negative
        issue(1, 255, 255, 255, 255,   0, 0,   0,  0, 255, E_M255, 1);  // residual -255
        idle(6);
        @(negedge clk);
        chk("hold_Px", int'(Px), 255);
        chk("hold_en_out", int'(en_out), 0);

        // Streaming: flat 128 neighbourhood, residual = Ix - 128
        for (int i = 0; i < 512; i++)
            issue(1, 128, 128, 128, 128, 8'(i), (i == 511), 0, 0, 128, (i % 256) - 128, 1);
        issue(1, 128, 128, 128, 128,   5, 0, 0, 0, 128, -123, 1);
        idle(1);
        issue(1, 128, 128, 128, 128, 250, 0, 0, 0, 128,  122, 1);
        idle(1);
        issue(1, 128, 128, 128, 128, 128, 0, 0, 0, 128,    0, 1);
        idle(6);

        // Reset mid-stream: only the first sample reaches the output before reset
        issue(1, 100, 100, 100, 100, 100, 0,   0, 0, 100, 0, 1);
        issue(0,  10,  20,  30,  50,  15, 0, 300, 0,  10, 5, 0);
        issue(0,  50,  30,  20,  10,  40, 0, 220, 1,  50, 10, 0);
        @(posedge clk);
        #1;
        en = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_zero("midreset");
        @(posedge clk);
        #1 reset = 1'b1;
        idle(8);

        @(negedge clk);
        chk("outputs_seen", n_out, n_exp);
        chk("queue_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
